// File: rtl/config_chain_loader.sv
`timescale 1ns/1ps
// config_chain_loader: master end of the DSP serial configuration chain.
// Takes configuration words from a valid/ready stream, shifts them LSB first
// into the chain head and assembles the bits leaving the chain tail into
// readback words, so the previous configuration comes back during the load.
module config_chain_loader #(
  parameter int CHAIN_LEN = 10,
  parameter int WORD_W    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              cfg_si,
  output logic              cfg_en,
  input  logic              cfg_so,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
);

  localparam int TW = $clog2(CHAIN_LEN + 1);
  localparam int BW = $clog2(WORD_W + 1);
  localparam logic [TW-1:0] TOTAL_LAST = TW'(CHAIN_LEN - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(WORD_W - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] sr_q, sr_d;
  logic [WORD_W-1:0] rb_acc_q, rb_acc_d;
  logic [WORD_W-1:0] rb_data_q, rb_data_d;
  logic              rb_valid_q, rb_valid_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [TW-1:0]     total_cnt_q, total_cnt_d;
  logic              word_last;

  // A word ends on its last bit, or earlier when the chain runs out of bits.
  assign word_last = (bit_cnt_q == BIT_LAST) || (total_cnt_q == TOTAL_LAST);

  // Next-state logic for the sequencer, shift register, counters and readback.
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    rb_acc_d    = rb_acc_q;
    rb_data_d   = rb_data_q;
    rb_valid_d  = 1'b0;
    bit_cnt_d   = bit_cnt_q;
    total_cnt_d = total_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = LOAD;
          total_cnt_d = '0;
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
        end else if (s_valid) begin
          sr_d      = s_data;
          rb_acc_d  = '0;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          sr_d = sr_q >> 1;
          for (int i = 0; i < WORD_W; i++) begin
            if (bit_cnt_q == BW'(i)) begin
              rb_acc_d[i] = cfg_so;
            end
          end
          bit_cnt_d   = bit_cnt_q + 1'b1;
          total_cnt_d = total_cnt_q + 1'b1;
          if (word_last) begin
            rb_data_d  = rb_acc_d;
            rb_valid_d = 1'b1;
            state_d    = (total_cnt_q == TOTAL_LAST) ? DONE : LOAD;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset clears everything so cfg_en drops immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      rb_acc_q    <= '0;
      rb_data_q   <= '0;
      rb_valid_q  <= 1'b0;
      bit_cnt_q   <= '0;
      total_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      rb_acc_q    <= rb_acc_d;
      rb_data_q   <= rb_data_d;
      rb_valid_q  <= rb_valid_d;
      bit_cnt_q   <= bit_cnt_d;
      total_cnt_q <= total_cnt_d;
    end
  end

  assign s_ready  = (state_q == LOAD);
  assign cfg_en   = (state_q == SHIFT);
  assign cfg_si   = (state_q == SHIFT) & sr_q[0];
  assign busy     = (state_q == LOAD) || (state_q == SHIFT);
  assign done     = (state_q == DONE);
  assign rb_data  = rb_data_q;
  assign rb_valid = rb_valid_q;

endmodule

// File: tb/tb_config_chain_loader.sv
`timescale 1ns/1ps
// Directed bench for config_chain_loader. Three instances cover the default
// 10-bit/4-bit geometry, a single full-width 8-bit word and a one-bit chain.
// Each chain is modelled as a plain shift register fed from cfg_si.
module tb_config_chain_loader;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic       start, abort, s_valid, s_ready, cfg_si, cfg_en, cfg_so, busy, done, rb_valid;
  logic [3:0] s_data, rb_data;

  logic       start8, abort8, s_valid8, s_ready8, cfg_si8, cfg_en8, cfg_so8, busy8, done8, rb_valid8;
  logic [7:0] s_data8, rb_data8;

  logic       start1, abort1, s_valid1, s_ready1, cfg_si1, cfg_en1, cfg_so1, busy1, done1, rb_valid1;
  logic [3:0] s_data1, rb_data1;

  logic [9:0] chain = '0;
  logic [9:0] chain_preset = '0;
  logic [7:0] chain8 = '0;
  logic [7:0] chain8_preset = 8'h1E;
  logic       chain1 = 1'b0;
  logic       chain1_preset = 1'b1;
  logic       preset_req = 1'b0;
  logic       mon_clear = 1'b0;

  int          en_cnt = 0, run_len = 0, done_cnt = 0, rb_cnt = 0;
  logic [15:0] si_log = '0, runs_log = '0;
  logic [31:0] rb_log = '0;
  int          en_cnt8 = 0, rb_cnt8 = 0, en_cnt1 = 0, rb_cnt1 = 0;

  always #5 clk = ~clk;

  config_chain_loader #(.CHAIN_LEN(10), .WORD_W(4)) u_dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .cfg_si(cfg_si), .cfg_en(cfg_en), .cfg_so(cfg_so),
    .busy(busy), .done(done), .rb_data(rb_data), .rb_valid(rb_valid)
  );

  config_chain_loader #(.CHAIN_LEN(8), .WORD_W(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(start8), .abort(abort8),
    .s_data(s_data8), .s_valid(s_valid8), .s_ready(s_ready8),
    .cfg_si(cfg_si8), .cfg_en(cfg_en8), .cfg_so(cfg_so8),
    .busy(busy8), .done(done8), .rb_data(rb_data8), .rb_valid(rb_valid8)
  );

  config_chain_loader #(.CHAIN_LEN(1), .WORD_W(4)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .abort(abort1),
    .s_data(s_data1), .s_valid(s_valid1), .s_ready(s_ready1),
    .cfg_si(cfg_si1), .cfg_en(cfg_en1), .cfg_so(cfg_so1),
    .busy(busy1), .done(done1), .rb_data(rb_data1), .rb_valid(rb_valid1)
  );

  assign cfg_so  = chain[9];
  assign cfg_so8 = chain8[7];
  assign cfg_so1 = chain1;

  // Chain models: the first bit shifted in ends up nearest the tail.
  always @(posedge clk) begin
    if (preset_req) begin
      chain  <= chain_preset;
      chain8 <= chain8_preset;
      chain1 <= chain1_preset;
    end else begin
      if (cfg_en)  chain  <= {chain[8:0], cfg_si};
      if (cfg_en8) chain8 <= {chain8[6:0], cfg_si8};
      if (cfg_en1) chain1 <= cfg_si1;
    end
  end

  // Activity monitors: enable counts, enable run lengths, serial stream, readback words.
  always @(posedge clk) begin
    if (mon_clear) begin
      en_cnt = 0; run_len = 0; done_cnt = 0; rb_cnt = 0;
      si_log = '0; runs_log = '0; rb_log = '0;
      en_cnt8 = 0; rb_cnt8 = 0; en_cnt1 = 0; rb_cnt1 = 0;
    end else begin
      if (cfg_en) begin
        si_log = {si_log[14:0], cfg_si};
        en_cnt++;
        run_len++;
      end else if (run_len > 0) begin
        runs_log = {runs_log[11:0], 4'(run_len)};
        run_len = 0;
      end
      if (done) done_cnt++;
      if (rb_valid) begin
        rb_log = {rb_log[27:0], rb_data};
        rb_cnt++;
      end
      if (cfg_en8) en_cnt8++;
      if (rb_valid8) rb_cnt8++;
      if (cfg_en1) en_cnt1++;
      if (rb_valid1) rb_cnt1++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic prepare(input logic do_preset);
    preset_req = do_preset;
    mon_clear  = 1'b1;
    step();
    preset_req = 1'b0;
    mon_clear  = 1'b0;
  endtask

  task automatic waitReady(input string tag);
    int n = 0;
    while (!s_ready && n < 50) begin
      step();
      n++;
    end
    checkOutput(tag, 32'(s_ready), 32'd1);
  endtask

  // Offer one word to the default instance and return just after it is taken.
  task automatic applyStimulus(input logic [3:0] w);
    s_data  = w;
    s_valid = 1'b1;
    waitReady("handshake_ready");
    step();
    s_valid = 1'b0;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Last word of a load is two bits: done follows two edges after its handshake.
  task automatic finishLoad(input string tag, input logic [3:0] last_rb);
    step();
    step();
    checkOutput({tag, "_done_pulse"}, 32'({done, rb_valid, rb_data}), 32'({2'b11, last_rb}));
    step();
    checkOutput({tag, "_done_drop"}, 32'({done, busy}), 32'd0);
  endtask

  task automatic checkLoad(input string tag, input logic [31:0] rb_exp);
    checkOutput({tag, "_en_cnt"}, 32'(en_cnt), 32'd10);
    checkOutput({tag, "_runs"}, 32'(runs_log), 32'h0442);
    checkOutput({tag, "_si_stream"}, 32'(si_log), 32'h016B);
    checkOutput({tag, "_chain"}, 32'(chain), 32'h16B);
    checkOutput({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    checkOutput({tag, "_rb_cnt"}, 32'(rb_cnt), 32'd3);
    checkOutput({tag, "_rb_words"}, rb_log, rb_exp);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0;
    start8 = 1'b0; abort8 = 1'b0; s_valid8 = 1'b0; s_data8 = '0;
    start1 = 1'b0; abort1 = 1'b0; s_valid1 = 1'b0; s_data1 = '0;
    #1;
    checkOutput("reset_outputs", 32'({s_ready, cfg_en, cfg_si, busy, done, rb_valid, rb_data}), 32'd0);
    checkOutput("reset_outputs8", 32'({s_ready8, cfg_en8, cfg_si8, busy8, done8, rb_valid8, rb_data8}), 32'd0);
    repeat (2) step();
    reset = 1'b0;

    $display("[TB] idle ignores abort and s_valid");
    abort = 1'b1; s_valid = 1'b1; s_data = 4'hF;
    step();
    abort = 1'b0; s_valid = 1'b0;
    checkOutput("idle_ignores", 32'({busy, s_ready, cfg_en}), 32'd0);

    $display("[TB] basic load into a cleared chain, start and abort together");
    chain_preset = 10'h000;
    prepare(1'b1);
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    checkOutput("start_wins", 32'({busy, s_ready}), 32'd3);
    applyStimulus(4'hA);
    applyStimulus(4'h5);
    applyStimulus(4'h3);
    finishLoad("basic", 4'h0);
    checkLoad("basic", 32'h0000);

    $display("[TB] backpressure with chain preset to all ones");
    chain_preset = 10'h3FF;
    prepare(1'b1);
    pulseStart();
    applyStimulus(4'hA);
    waitReady("bp_ready");
    begin
      int viol = 0;
      for (int i = 0; i < 5; i++) begin
        if (!s_ready || cfg_en) viol++;
        step();
      end
      checkOutput("bp_gap_hold", 32'(viol), 32'd0);
    end
    applyStimulus(4'h5);
    applyStimulus(4'h3);
    finishLoad("bp", 4'h3);
    checkLoad("bp", 32'h0FF3);

    $display("[TB] reload reads back previous load, start while busy ignored");
    prepare(1'b0);
    pulseStart();
    applyStimulus(4'hA);
    pulseStart();
    applyStimulus(4'h5);
    applyStimulus(4'h3);
    finishLoad("reload", 4'h3);
    checkLoad("reload", 32'h0A53);

    $display("[TB] abort while waiting for word 3");
    chain_preset = 10'h000;
    prepare(1'b1);
    pulseStart();
    applyStimulus(4'hA);
    pulseStart();
    applyStimulus(4'h5);
    waitReady("abort_ready");
    abort = 1'b1;
    step();
    abort = 1'b0;
    checkOutput("abort_idle", 32'({busy, s_ready, cfg_en}), 32'd0);
    repeat (4) step();
    checkOutput("abort_no_done", 32'(done_cnt), 32'd0);
    checkOutput("abort_rb_cnt", 32'(rb_cnt), 32'd2);
    checkOutput("abort_en_cnt", 32'(en_cnt), 32'd8);
    checkOutput("abort_chain", 32'(chain), 32'h05A);

    $display("[TB] reset in the middle of word 2");
    prepare(1'b1);
    pulseStart();
    applyStimulus(4'hA);
    applyStimulus(4'h5);
    begin
      int n = 0;
      while (en_cnt < 6 && n < 50) begin
        step();
        n++;
      end
    end
    checkOutput("rst_mid_en_cnt", 32'(en_cnt), 32'd6);
    reset = 1'b1;
    #1;
    checkOutput("rst_mid_async", 32'({cfg_en, busy, s_ready, done}), 32'd0);
    step();
    reset = 1'b0;
    step();
    checkOutput("rst_mid_no_done", 32'(done_cnt), 32'd0);
    checkOutput("rst_mid_chain", 32'(chain), 32'h016);
    prepare(1'b0);
    pulseStart();
    applyStimulus(4'hA);
    applyStimulus(4'h5);
    applyStimulus(4'h3);
    finishLoad("after_rst", 4'h1);
    checkLoad("after_rst", 32'h00A1);

    $display("[TB] single full-width word, 8-bit chain");
    prepare(1'b1);
    start8 = 1'b1;
    step();
    start8 = 1'b0;
    checkOutput("w8_ready", 32'(s_ready8), 32'd1);
    s_data8 = 8'hC3; s_valid8 = 1'b1;
    step();
    s_valid8 = 1'b0;
    repeat (8) step();
    checkOutput("w8_done", 32'({done8, rb_valid8, rb_data8}), 32'h378);
    step();
    checkOutput("w8_en_cnt", 32'(en_cnt8), 32'd8);
    checkOutput("w8_rb_cnt", 32'(rb_cnt8), 32'd1);
    checkOutput("w8_chain", 32'(chain8), 32'hC3);
    checkOutput("w8_idle", 32'({done8, busy8}), 32'd0);

    $display("[TB] one-bit chain uses only s_data[0]");
    prepare(1'b1);
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    s_data1 = 4'b1110; s_valid1 = 1'b1;
    step();
    s_valid1 = 1'b0;
    step();
    checkOutput("c1_done", 32'({done1, rb_valid1, rb_data1}), 32'h31);
    step();
    checkOutput("c1_en_cnt", 32'(en_cnt1), 32'd1);
    checkOutput("c1_rb_cnt", 32'(rb_cnt1), 32'd1);
    checkOutput("c1_chain", 32'(chain1), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Backstop in case a wait above is ever unbounded.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/config_chain_loader.md
Name: config_chain_loader

Overview:
- Writer/master end of the serial configuration chain used by the DSP sub-blocks. Each sub-block exposes configuration_input, configuration_enable and configuration_output.
- Accepts configuration words over a valid/ready stream and serialises them onto the chain head, driving the shared chain enable.
- Captures the bits falling out of the chain tail, so the previous configuration is read back while the new one loads.
- Sits at DSP tile level, between the bitstream source and the first block of the chain.

Parameters:
- CHAIN_LEN, 10, total configuration bits in the attached chain (>=1).
- WORD_W, 4, stream word width (>=1). Words per load NW = ceil(CHAIN_LEN/WORD_W).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a load; ignored unless IDLE.
- abort  in  1  synchronous cancel of a load in progress.
- s_data  in  WORD_W  configuration word; bit 0 is shifted first.
- s_valid  in  1  s_data valid.
- s_ready  out  1  loader accepts s_data this cycle.
- cfg_si  out  1  serial bit to chain head (connects to configuration_input of the first block).
- cfg_en  out  1  chain shift enable (connects to configuration_enable of every block).
- cfg_so  in  1  chain tail (configuration_output of the last block).
- busy  out  1  high in LOAD or SHIFT.
- done  out  1  one-cycle pulse after the last chain bit is shifted.
- rb_data  out  WORD_W  readback word of old chain contents.
- rb_valid  out  1  one-cycle pulse; rb_data valid.

Behaviour:
- Reset values: s_ready=0, cfg_en=0, cfg_si=0, busy=0, done=0, rb_valid=0, rb_data=0. State is IDLE; bit and word counters are 0.
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - start=1 -> LOAD; total bit counter cleared.
  - No other input has an effect.
- LOAD:
  - s_ready=1.
  - s_valid&s_ready at an edge -> word latched into the shift register, state -> SHIFT.
  - Exactly one bubble cycle (cfg_en=0) separates consecutive words.
- SHIFT:
  - cfg_en=1 and cfg_si = current shift-register LSB; register shifts right each cycle.
  - Shift length per word is min(WORD_W, CHAIN_LEN - bits already shifted). Upper bits of a partial final word are discarded.
  - After a word's last bit: go to DONE if the total reaches CHAIN_LEN, else back to LOAD.
- DONE: done=1 for one cycle, then IDLE.
- Total cfg_en-high cycles per completed load = CHAIN_LEN exactly, whatever s_valid gaps occur. cfg_en is never high outside SHIFT.
- Readback:
  - During each cfg_en-high cycle, cfg_so (pre-edge value) is shifted into a readback register at index = bit position within the current word.
  - When a word's last bit is sampled, rb_data updates on that edge and rb_valid pulses the next cycle.
  - Partial final word: unused upper bits are 0.
  - rb_data holds its value until the next update.
- busy = (state==LOAD || state==SHIFT).
- abort=1 in LOAD or SHIFT -> IDLE at next edge. No done, no further rb_valid. Chain keeps partially shifted contents. abort in IDLE/DONE is ignored.
- start while busy is ignored. start and abort together in IDLE -> start wins.
- reset mid-load: all outputs go to reset values immediately (cfg_en drops asynchronously). No done pulse.
- Widths: counters are $clog2(CHAIN_LEN+1) and $clog2(WORD_W+1) bits; no wrap within a load.

Test Plan:
- Basic load: chain modelled as a 10-bit shift register preset to 0, start, words 4'hA, 4'h5, 4'h3 with s_valid always high -> cfg_si stream 0,1,0,1,1,0,1,0,1,1. cfg_en high exactly 10 cycles in groups 4/4/2, one bubble between groups. done pulses once, 1 cycle after the last shift.
- Readback: chain preset to 10'h3FF, load as above -> rb_valid pulses three times with rb_data 4'hF, 4'hF, 4'h3. The chain then holds the new pattern.
- Backpressure: s_valid low for 5 cycles before word 2 -> s_ready stays high, cfg_en low throughout the gap. Chain contents and readback are identical to the basic load.
- Reset mid-SHIFT: reset asserted after 6 shifted bits -> cfg_en, busy, s_ready go 0 without waiting for a clock edge. No done. Chain holds 6 new bits. A fresh load afterwards completes normally.
- Abort and ignored start: abort in LOAD of word 3 -> IDLE next cycle, no done, only 2 rb_valid pulses. A start pulsed while busy leaves the cfg_en count unchanged.
- Parameter corner: CHAIN_LEN=8, WORD_W=8, word 8'hC3 -> 8 shifts, single rb_valid, done. With CHAIN_LEN=1 -> 1 shift, only s_data[0] used.
